// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART blocks: frame constants,
//                FSM state encoding and the bit-timing counter width helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud

    // Transmitter FSM state encoding
    typedef logic [1:0] uart_state_t;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // Width of a counter holding 0..clks-1; never narrower than one bit.
    function automatic int cnt_width(input int clks);
        return (clks > 2) ? $clog2(clks) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : Integer bit-period divider. Counts 0..CLKS_PER_BIT-1 while
//                enabled and flags the terminal count with a one-cycle
//                bit_done pulse.
//  Ports       : clk      - system clock
//                rst      - asynchronous active-high reset
//                clear    - synchronous clear, forces the count to zero
//                enable   - count when high
//                bit_done - high during the last cycle of each bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);

    localparam int               CNT_W  = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_terminal;

    assign w_terminal = (r_cnt == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_terminal ? '0 : (r_cnt + c_one);
        end
    end

    // Combinational so the consumer advances on the same edge the count wraps.
    assign bit_done = enable & ~clear & w_terminal;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART transmitter. Captures a byte on an accepted start
//                request and shifts it out LSB first between a low start bit
//                and a high stop bit. Bit timing from uart_baud_cnt.
//  Ports       : clk     - system clock, rising edge
//                rst     - asynchronous active-high reset
//                start   - transmit request, level-sampled while idle
//                data_in - byte to send, captured on acceptance
//                tx      - registered serial output, idles high
//                busy    - registered, high while a frame is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy
);

    localparam int               IDX_W      = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);

    uart_state_t          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_tx;
    logic                 r_busy;

    logic                 w_bit_done;
    logic                 w_idle;
    logic [IDX_W-1:0]     w_next_idx;

    assign w_idle     = (r_state == IDLE);
    assign w_next_idx = r_idx + c_idx_one;

    // The divider is held at zero while idle, so the first bit period after
    // acceptance is a full CLKS_PER_BIT cycles.
    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_idle),
        .enable   (~w_idle),
        .bit_done (w_bit_done)
    );

    // tx is loaded with the level of the next bit on each transition so the
    // line changes exactly on the edge that ends the previous bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_shift <= data_in;
                        r_idx   <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        if (r_idx == c_last_idx) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_idx <= w_next_idx;
                            r_tx  <= r_shift[w_next_idx];
                        end
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx (CLKS_PER_BIT=4). A model
//                decides which requests are accepted and queues the expected
//                frame; a monitor compares each observed frame against it.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int N     = 4;
    localparam int FRAME = 10 * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc         = 0;
    int   free_at     = 0;
    int   frames_done = 0;
    int   idle_err    = 0;
    bit   cap         = 1'b0;

    uart_tx #(
        .CLKS_PER_BIT (N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a request is taken at any rising edge with start high
    // once the previous frame (10 bit times) plus one idle cycle has elapsed.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                free_at = 0;
            end else if (start && cyc >= free_at) begin
                q.push_back('{data: data_in, cyc: cyc});
                free_at = cyc + FRAME + 1;
            end
        end
    end

    // Monitor: a rising busy opens a frame; every cycle of it is compared with
    // the expected bit pattern {stop, data LSB first, start}.
    initial begin
        exp_t       e;
        logic [9:0] fr;
        int         k;
        int         tx_err;
        int         busy_err;
        fr = '0; k = 0; tx_err = 0; busy_err = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cap = 1'b0;
            end else begin
                if (!cap && busy) begin
                    if (q.size() == 0) begin
                        check("unexpected_frame", 32'(busy), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("accept_time", 32'(cyc), 32'(e.cyc));
                        fr       = {1'b1, e.data, 1'b0};
                        k        = 0;
                        tx_err   = 0;
                        busy_err = 0;
                        cap      = 1'b1;
                    end
                end else if (!cap && tx !== 1'b1) begin
                    idle_err++;
                end
                if (cap) begin
                    if (k < FRAME) begin
                        if (tx !== fr[k / N]) tx_err++;
                        if (busy !== 1'b1)    busy_err++;
                        k++;
                    end else begin
                        check("frame_tx_errors", 32'(tx_err), 32'd0);
                        check("busy_held_errors", 32'(busy_err), 32'd0);
                        check("stop_to_idle", {30'd0, busy, tx}, 32'b01);
                        frames_done++;
                        cap = 1'b0;
                    end
                end
            end
        end
    end

    task automatic drive(input logic s, input logic [7:0] d);
        @(negedge clk);
        #2;
        start   = s;
        data_in = d;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int rst_err;
        int f0;
        int waited;

        // Reset held with start asserted: nothing may start.
        rst = 1'b1; start = 1'b1; data_in = 8'hAA;
        rst_err = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) rst_err++;
        end
        check("reset_hold_errors", 32'(rst_err), 32'd0);

        // Single frame 0xAA, start held 10 cycles after release.
        f0 = frames_done;
        @(negedge clk); #2; rst = 1'b0;
        idle_cycles(10);
        #2; start = 1'b0;
        idle_cycles(40);
        check("single_frame_count", 32'(frames_done - f0), 32'd1);

        // Data captured at acceptance; later changes must not leak in.
        drive(1'b1, 8'h0F);
        drive(1'b0, 8'hFF);
        idle_cycles(45);

        // Back-to-back frames with start held high.
        f0 = frames_done;
        drive(1'b1, 8'h55);
        idle_cycles(84);
        #2; start = 1'b0;
        idle_cycles(45);
        check("back_to_back_count", 32'(frames_done - f0), 32'd3);

        // Asynchronous reset during data bit 3.
        drive(1'b1, 8'hC3);
        drive(1'b0, 8'hC3);
        idle_cycles(16);
        #5; rst = 1'b1;
        #1;
        check("async_reset_tx", 32'(tx), 32'd1);
        check("async_reset_busy", 32'(busy), 32'd0);
        idle_cycles(3);
        #2; rst = 1'b0; start = 1'b1; data_in = 8'h96;
        f0 = frames_done;
        drive(1'b0, 8'h96);
        idle_cycles(45);
        check("after_reset_frame_count", 32'(frames_done - f0), 32'd1);

        // Boundary bytes.
        drive(1'b1, 8'h00);
        drive(1'b0, 8'h00);
        idle_cycles(45);
        drive(1'b1, 8'hFF);
        drive(1'b0, 8'h00);
        idle_cycles(45);

        // Randomised requests, including ones that land while busy.
        repeat (600) begin
            drive(($urandom_range(0, 7) == 0), 8'($urandom));
        end
        drive(1'b0, 8'h00);

        // Drain with a bounded wait.
        waited = 0;
        while ((q.size() != 0 || cap) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain_pending", 32'(q.size()) + 32'(cap), 32'd0);
        idle_cycles(2);
        check("idle_tx_errors", 32'(idle_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: accepts one byte on a start request and shifts it out on a single line.
- Frame format is 8N1: start bit, 8 data bits LSB first, no parity, 1 stop bit.
- Sits between a byte producer (controller/FSM) and the board TX pin.
- Bit timing is derived from the system clock by an integer divider.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud). Legal range 2 or more.

Ports:
- clk  input  1  system clock (nominal 50 MHz); all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  transmit request; level-sampled.
- data_in  input  8  byte to send; captured when the request is accepted.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst=1, asynchronous) forces:
  - state=IDLE, tx=1, busy=0;
  - bit counter, clock-divider counter and shift register to 0.
- Releasing reset returns the block to normal operation; the first possible acceptance is the first rising edge with rst=0.
- State IDLE:
  - tx=1, busy=0.
  - On a rising edge with start=1: latch data_in into the shift register, clear the divider, go to START.
- State START:
  - tx=0, busy=1, held for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- State DATA:
  - tx = shift register bit[index], held CLKS_PER_BIT cycles per bit.
  - Index advances 0..7; after bit 7 completes, go to STOP.
- State STOP:
  - tx=1, busy=1 for CLKS_PER_BIT cycles, then go to IDLE (busy=0).
- Outputs tx and busy are registered. tx falls, and busy rises, on the same edge that accepts start.
- Latency and frame length:
  - The frame occupies exactly 10*CLKS_PER_BIT cycles from the accepting edge.
  - busy falls exactly 10*CLKS_PER_BIT cycles after it rose.
- Start handling:
  - start is ignored while busy=1, whether held high or pulsed.
  - data_in changes during a frame have no effect.
  - If start is still or again high in the first IDLE cycle, a new frame is accepted then. Back-to-back frames therefore have one idle (tx=1, busy=0) cycle between stop bit and next start bit.
- The divider counts 0..CLKS_PER_BIT-1; its terminal count advances the state or bit index. No fractional baud.
- Reset mid-frame aborts immediately: tx returns high, busy low; no partial bits are resumed.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP} (2 bits);
  - constants DATA_BITS=8 and the default CLKS_PER_BIT;
  - counter width computed as clog2(CLKS_PER_BIT).
- One natural sub-module: uart_baud_cnt.
  - Parameterised divider with synchronous clear input and a one-cycle bit_done pulse.
  - Reused by a future uart_rx.
- The FSM, shift register and bit index live in uart_tx.

Test Plan (CLKS_PER_BIT=4, 20 ns clock):
- Reset: rst=1 for 5 cycles with start=1 -> tx=1, busy=0 throughout; no frame starts until the first edge after rst falls.
- Single frame:
  - Stimulus: data_in=8'hAA, start=1 held 10 cycles, then 0.
  - tx sequence, each level held 4 cycles: 0 (start), 0,1,0,1,0,1,0,1 (data), 1 (stop).
  - busy high for exactly 40 cycles; only one frame sent.
- Data latch: data_in=8'h0F, start pulsed 1 cycle, data_in changed to 8'hFF the next cycle -> transmitted bits are 1,1,1,1,0,0,0,0.
- Back-to-back: start held high with 8'h55 -> second start bit begins exactly 41 cycles after the first accept; busy low for exactly 1 cycle between frames.
- Mid-frame reset: rst asserted during data bit 3 -> tx=1 and busy=0 immediately, without waiting for a clock edge. After release with start=1, a full fresh frame is sent.
- Boundary 8'h00 and 8'hFF:
  - 8'h00 -> tx low for 36 consecutive cycles (start plus 8 data bits), then a stop bit high for 4 cycles.
  - 8'hFF -> tx low for exactly 4 cycles (start bit only).
